// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU types: boot/load sequencing states and width defaults.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_arbiter
// Brief    : Shares the instruction memory between fetch and a streaming
//            program loader, and holds/releases the CPU around loads.
// Revision : 1.0
// ============================================================================
module imem_boot_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_stall,
  output logic              cpu_halt,
  input  logic              ld_start,
  input  logic              ld_skip,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ld_count,
  output logic              ld_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] ld_count_q, ld_count_d;
  logic              ld_overflow_q, ld_overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      wr_ptr_q      <= '0;
      ld_count_q    <= '0;
      ld_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ld_count_q    <= ld_count_d;
      ld_overflow_q <= ld_overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    ld_count_d    = ld_count_q;
    ld_overflow_d = ld_overflow_q;
    fetch_stall   = 1'b1;
    cpu_halt      = 1'b1;
    ld_ready      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = wr_ptr_q;
    mem_wdata     = ld_data;
    fetch_data    = '0;

    unique case (state_q)
      BOOT: begin
        if (ld_start) begin
          state_d = LOAD;
        end else if (ld_skip) begin
          state_d = FLUSH;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we     = 1'b1;
          ld_count_d = ld_count_q + ONE;
          if (ld_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d = FLUSH;
          end
          // Pointer parks on the last word so it never leaves the array.
          if (wr_ptr_q == LAST_ADDR) begin
            ld_overflow_d = !ld_last;
          end else begin
            wr_ptr_d = wr_ptr_q + ONE;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      RUN: begin
        fetch_stall = 1'b0;
        cpu_halt    = 1'b0;
        mem_addr    = fetch_addr;
        fetch_data  = mem_rdata;
        if (ld_start) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if ((state_d == LOAD) && (state_q != LOAD)) begin
      wr_ptr_d      = '0;
      ld_count_d    = '0;
      ld_overflow_d = 1'b0;
    end
  end

  assign ld_count    = ld_count_q;
  assign ld_overflow = ld_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_arbiter
// Brief    : Bench for imem_boot_arbiter with a behavioural model and RAM.
// Revision : 1.0
// ============================================================================
module tb_imem_boot_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8;

  localparam int M_HALT  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_RUN   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fetch_addr = '0;
  logic          ld_start = 1'b0;
  logic          ld_skip  = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data  = '0;
  logic          ld_last  = 1'b0;
  logic [DW-1:0] fetch_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr, ld_count;
  logic          fetch_stall, cpu_halt, ld_ready, mem_we, ld_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_boot_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_stall(fetch_stall), .cpu_halt(cpu_halt), .ld_start(ld_start),
    .ld_skip(ld_skip), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .ld_count(ld_count), .ld_overflow(ld_overflow)
  );

  function automatic logic [DW-1:0] seed_word(int i);
    return DW'(i * 32'h1357 ^ 32'h0F0F);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // External async-read RAM; out-of-range reads return a marker.
  logic [DW-1:0] ram [DEPTH];
  bit            ram_seeded = 1'b0;
  int            n_writes = 0;
  assign mem_rdata = (mem_addr < DEPTH) ? ram[mem_addr[2:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = seed_word(i);
      ram_seeded = 1'b1;
    end
    if (mem_we === 1'b1) begin
      n_writes++;
      if (mem_addr < DEPTH) ram[mem_addr[2:0]] = mem_wdata;
    end
  end

  // Behavioural model: phase, words loaded, overflow flag, expected memory image.
  int            m_mode  = M_HALT;
  int            m_count = 0;
  bit            m_ovf   = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_seeded = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (!m_seeded) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = seed_word(i);
      m_seeded = 1'b1;
    end
    if (rst) begin
      m_mode = M_HALT; m_count = 0; m_ovf = 1'b0;
    end else begin
      case (m_mode)
        M_HALT: begin
          if (ld_start) begin m_mode = M_LOAD; m_count = 0; m_ovf = 1'b0; end
          else if (ld_skip) m_mode = M_FLUSH;
        end
        M_LOAD: begin
          if (ld_valid) begin
            m_mem[m_count] = ld_data;
            m_count++;
            if (ld_last || m_count == DEPTH) m_mode = M_FLUSH;
            if (m_count == DEPTH && !ld_last) m_ovf = 1'b1;
          end
        end
        M_FLUSH: m_mode = M_RUN;
        default: begin
          if (ld_start) begin m_mode = M_LOAD; m_count = 0; m_ovf = 1'b0; end
        end
      endcase
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      bit            run;
      bit            we_exp;
      logic [AW-1:0] addr_exp;
      logic [DW-1:0] data_exp;
      run      = (m_mode == M_RUN);
      we_exp   = (m_mode == M_LOAD) && ld_valid;
      addr_exp = run ? fetch_addr : AW'((m_count < DEPTH) ? m_count : DEPTH - 1);
      data_exp = !run ? '0 : ((fetch_addr < DEPTH) ? m_mem[fetch_addr[2:0]] : 16'hDEAD);
      chk("fetch_stall", 32'(fetch_stall), 32'(!run));
      chk("cpu_halt", 32'(cpu_halt), 32'(!run));
      chk("ld_ready", 32'(ld_ready), 32'(m_mode == M_LOAD));
      chk("mem_we", 32'(mem_we), 32'(we_exp));
      chk("mem_addr", 32'(mem_addr), 32'(addr_exp));
      chk("fetch_data", 32'(fetch_data), 32'(data_exp));
      chk("ld_count", 32'(ld_count), 32'(m_count));
      chk("ld_overflow", 32'(ld_overflow), 32'(m_ovf));
      if (we_exp) chk("mem_wdata", 32'(mem_wdata), 32'(ld_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_start = 1'b0; ld_skip = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] words [4];
    logic [4:0]    gap_pat;
    int            w0;
    words   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    gap_pat = 5'b11001;

    #1 chk_on = 1'b1;
    #6;
    chk("rst_halt", 32'(cpu_halt), 32'd1);
    chk("rst_stall", 32'(fetch_stall), 32'd1);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_fetch_data", 32'(fetch_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    rst = 1'b0;

    // Basic load of four words.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_data = words[k]; ld_last = (k == 3); tick();
    end
    idle_inputs();
    #1;
    chk("load4_count", 32'(ld_count), 32'd4);
    for (int k = 0; k < 4; k++) chk("load4_mem", 32'(ram[k]), 32'(words[k]));
    chk("flush_halt", 32'(cpu_halt), 32'd1);
    tick();
    fetch_addr = '0;
    #1;
    chk("first_fetch", 32'(fetch_data), 32'h1111);
    chk("first_run_halt", 32'(cpu_halt), 32'd0);

    // Hot reload with gaps in ld_valid.
    repeat (3) begin fetch_addr = AW'($urandom_range(0, DEPTH - 1)); tick(); end
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    #1;
    chk("hot_halt", 32'(cpu_halt), 32'd1);
    chk("hot_stall", 32'(fetch_stall), 32'd1);
    chk("hot_ready", 32'(ld_ready), 32'd1);
    w0 = n_writes;
    for (int k = 0; k < 5; k++) begin
      ld_valid = gap_pat[k]; ld_data = DW'($urandom); ld_last = (k == 4); tick();
    end
    idle_inputs();
    #1;
    chk("gap_writes", 32'(n_writes - w0), 32'd3);
    chk("gap_count", 32'(ld_count), 32'd3);
    tick();

    // Overflow: full depth without ld_last.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      ld_valid = 1'b1; ld_data = DW'($urandom); tick();
    end
    idle_inputs();
    #1;
    chk("ovf_flag", 32'(ld_overflow), 32'd1);
    chk("ovf_count", 32'(ld_count), 32'd8);
    chk("ovf_flush_stall", 32'(fetch_stall), 32'd1);
    tick();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    #1;
    chk("ovf_cleared", 32'(ld_overflow), 32'd0);
    ld_valid = 1'b1; ld_data = 16'hBEEF; tick();
    ld_data = 16'hCAFE; ld_last = 1'b1; tick();
    idle_inputs();
    tick();
    fetch_addr = '0;
    #1;
    chk("reload_fetch", 32'(fetch_data), 32'hBEEF);
    chk("reload_addr", 32'(mem_addr), 32'd0);

    // start+skip together, then skip alone.
    rst = 1'b1; tick(); rst = 1'b0;
    ld_start = 1'b1; ld_skip = 1'b1; tick(); idle_inputs();
    #1;
    chk("start_wins", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_data = 16'h0A0A; ld_last = 1'b1; tick(); idle_inputs();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    w0 = n_writes;
    ld_skip = 1'b1; tick(); ld_skip = 1'b0;
    #1;
    chk("skip_flush_halt", 32'(cpu_halt), 32'd1);
    chk("skip_no_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("skip_run", 32'(cpu_halt), 32'd0);
    chk("skip_no_writes", 32'(n_writes - w0), 32'd0);

    // Reset in the middle of a load.
    rst = 1'b1; tick(); rst = 1'b0;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hA5A5; tick();
    ld_data = 16'h5A5A; tick();
    ld_data = 16'h7777;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(ld_count), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_halt", 32'(cpu_halt), 32'd1);
    w0 = n_writes;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_rst_no_writes", 32'(n_writes - w0), 32'd0);
    chk("mid_rst_mem0", 32'(ram[0]), 32'hA5A5);
    chk("mid_rst_mem1", 32'(ram[1]), 32'h5A5A);
    idle_inputs();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      ld_start   = ($urandom_range(0, 15) == 0);
      ld_skip    = ($urandom_range(0, 7) == 0);
      ld_valid   = 1'($urandom_range(0, 1));
      ld_last    = ($urandom_range(0, 5) == 0);
      ld_data    = DW'($urandom);
      fetch_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 40))
                                               : AW'($urandom_range(0, DEPTH - 1));
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
